obf_seq_ctrl: RTL and testbench
===============================

// Module: obf_seq_ctrl
// PURPOSE
//  Sequencer for the obfuscation substitution LUT. Accepts one substitution request
//  (IGU index + sequence length) from the obfuscator front end. Steps the LUT
//  sub-pointer (ppc) through the sequence and presents each substitute word plus its
//  immediate to the fetch/decode side over a valid/ready handshake. Sits between the
//  index generator and obf_lut; drives the LUT's index/ppc inputs and consumes its outputs.
// PARAMETERS
//  IGU_W   7   width of substitution index (matches OBF_IGU_WIDTH)
//  PPC_W   4   width of sub-pointer into a LUT sequence (matches OBF_PPC_WIDTH)
//  LEN_W   4   width of sequence-length field (substitute instructions per request)
//  DATA_W  16  width of LUT sub/imm words (matches OBF_LUT_OUT_WIDTH)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous reset, active-high
//  flush        in   1       synchronous abort of current sequence (pipeline flush)
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid & req_ready
//  req_index    in   IGU_W   substitution index for the request
//  req_len      in   LEN_W   number of substitute instructions (0 = nothing to emit)
//  lut_index    out  IGU_W   index driven to LUT (registered)
//  lut_ppc      out  PPC_W   sub-pointer driven to LUT (registered)
//  lut_sub      in   DATA_W  LUT substitute word at lut_index/lut_ppc
//  lut_imm      in   DATA_W  LUT immediate word (entry after lut_sub)
//  lut_has_imm  in   1       current lut_sub consumes lut_imm (from format decoder)
//  out_valid    out  1       substitute word valid
//  out_ready    in   1       consumer accepts word when out_valid & out_ready
//  out_sub      out  DATA_W  = lut_sub while out_valid, else 0
//  out_imm      out  DATA_W  = lut_imm when out_valid & lut_has_imm, else 0
//  out_last     out  1       current word is final word of sequence
//  busy         out  1       state == RUN
//  err          out  1       one-cycle pulse: ppc overflow, sequence aborted
// BEHAVIOUR
//  Reset: state=IDLE, lut_index=0, lut_ppc=0, cnt=0, len_q=0.
//    Outputs after reset: req_ready=1, out_valid=0, out_sub=0, out_imm=0,
//    out_last=0, busy=0, err=0.
//  States: IDLE, RUN.
//  IDLE:
//    - req_ready=1.
//    - Accept with req_len!=0 -> latch lut_index=req_index, len_q=req_len,
//      lut_ppc=0, cnt=0, go RUN.
//    - Accept with req_len==0 -> consumed, no output, stay IDLE.
//  RUN:
//    - out_valid=1.
//    - out_last = (cnt == len_q-1).
//    - Word handshake:
//      - ppc += lut_has_imm ? 2 : 1
//      - cnt += 1
//  Last-word handshake:
//    - If req_valid in the same cycle, the new request is accepted back-to-back:
//      req_ready = out_last & out_ready.
//    - New req_len!=0 -> reload and stay RUN.
//    - Otherwise -> IDLE.
//    - No bubble between sequences.
//  Latency: request accepted at edge N -> out_valid=1 from cycle N+1.
//    Each subsequent word follows 1 cycle after the previous handshake.
//  out_valid & !out_ready: hold lut_index/lut_ppc/cnt stable. LUT is combinational,
//    so out_sub/out_imm stay stable while stalled.
//  PPC overflow: non-last handshake where ppc+step > 2^PPC_W-1:
//    - err=1 for one cycle, state -> IDLE, lut_ppc=0, cnt=0.
//    - Any request offered that cycle is NOT accepted.
//  flush (highest priority, over handshakes and overflow):
//    - Next edge -> state=IDLE, lut_ppc=0, cnt=0.
//    - req_ready=0 and out_valid forced 0 in the flush cycle; no handshake occurs.
//  rst mid-sequence: immediate return to reset values; no partial output.
//  Width rules: ppc/cnt arithmetic done in PPC_W+1 / LEN_W bits; no silent wrap.
// TESTING
//  1 reset: rst=1 mid-RUN -> out_valid=0, busy=0, req_ready=1, lut_ppc=0 asynchronously.
//  2 index=64, len=3, has_imm=0,1,0, out_ready=1 -> lut_ppc 0,1,3.
//    3 words, out_last on 3rd, IDLE after; out_imm nonzero only on word 2.
//  3 len=2 with out_ready=0 for 4 cycles on word 1 -> out_sub/lut_ppc stable.
//    Then 2 words, no duplicates.
//  4 back-to-back: seq A (len=1) last handshake with req_valid B (len=2) -> B accepted same edge.
//    B word 1 valid next cycle; no idle cycle.
//  5 flush during word 2 of len=4 -> out_valid=0 next cycle, state IDLE, no further words.
//  6 PPC_W=4, len=15, all has_imm=1 -> err pulse at ppc=14 handshake, IDLE, req_len=0 request accepted silently.

Source files
------------

// File: rtl/obf_seq_ctrl_if.sv
// Request / LUT / output bundle for the obfuscation sequencer.
// The slave modport is the sequencer's view. The master modport is the surrounding logic's view.
interface obf_seq_ctrl_if #(
  parameter int IGU_W  = 7,
  parameter int PPC_W  = 4,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 16
);
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [IGU_W-1:0]  req_index;
  logic [LEN_W-1:0]  req_len;
  logic [IGU_W-1:0]  lut_index;
  logic [PPC_W-1:0]  lut_ppc;
  logic [DATA_W-1:0] lut_sub;
  logic [DATA_W-1:0] lut_imm;
  logic              lut_has_imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sub;
  logic [DATA_W-1:0] out_imm;
  logic              out_last;
  logic              busy;
  logic              err;

  modport slave (
    input  flush, req_valid, req_index, req_len, lut_sub, lut_imm, lut_has_imm, out_ready,
    output req_ready, lut_index, lut_ppc, out_valid, out_sub, out_imm, out_last, busy, err
  );

  modport master (
    output flush, req_valid, req_index, req_len, lut_sub, lut_imm, lut_has_imm, out_ready,
    input  req_ready, lut_index, lut_ppc, out_valid, out_sub, out_imm, out_last, busy, err
  );
endinterface

// File: rtl/obf_seq_ctrl.sv
// Steps the substitution LUT through one sequence per request. Words appear one cycle after the request is accepted.
// When out_valid is high and out_ready is low, the index, ppc and count registers hold. A request can be accepted on the last-word handshake.
module obf_seq_ctrl #(
  parameter int IGU_W  = 7,
  parameter int PPC_W  = 4,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  obf_seq_ctrl_if.slave    bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [IGU_W-1:0]  index_q, index_d;
  logic [PPC_W-1:0]  ppc_q, ppc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;

  logic              run;
  logic              out_valid;
  logic              out_last;
  logic              out_hs;
  logic              req_ready;
  logic              load;
  logic [PPC_W:0]    ppc_sum;

  assign run       = (state_q == RUN);
  assign out_valid = run & ~bus.flush;
  assign out_last  = out_valid & (cnt_q == len_q - LEN_W'(1));
  assign out_hs    = out_valid & bus.out_ready;
  // Flush blocks acceptance. While running, only the last-word handshake frees the slot.
  assign req_ready = ~bus.flush & (~run | (out_last & bus.out_ready));
  assign load      = bus.req_valid & req_ready & (bus.req_len != '0);
  // One extra bit so that ppc overflow can be seen before the pointer is written.
  assign ppc_sum   = {1'b0, ppc_q} + (bus.lut_has_imm ? (PPC_W+1)'(2) : (PPC_W+1)'(1));

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    ppc_d   = ppc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      ppc_d   = '0;
      cnt_d   = '0;
    end else if (load) begin
      state_d = RUN;
      index_d = bus.req_index;
      len_d   = bus.req_len;
      ppc_d   = '0;
      cnt_d   = '0;
    end else if (out_hs) begin
      if (out_last) begin
        state_d = IDLE;
        ppc_d   = '0;
        cnt_d   = '0;
      end else if (ppc_sum[PPC_W]) begin
        err_d   = 1'b1;
        state_d = IDLE;
        ppc_d   = '0;
        cnt_d   = '0;
      end else begin
        ppc_d   = ppc_sum[PPC_W-1:0];
        cnt_d   = cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      ppc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ppc_q   <= ppc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.lut_index = index_q;
  assign bus.lut_ppc   = ppc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_sub   = out_valid ? bus.lut_sub : {DATA_W{1'b0}};
  assign bus.out_imm   = (out_valid & bus.lut_has_imm) ? bus.lut_imm : {DATA_W{1'b0}};
  assign bus.out_last  = out_last;
  assign bus.busy      = run;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_obf_seq_ctrl.sv
// Directed bench for obf_seq_ctrl. A small combinational LUT model encodes index and ppc into each word.
module tb_obf_seq_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  obf_seq_ctrl_if #(.IGU_W(7), .PPC_W(4), .LEN_W(4), .DATA_W(16)) bus ();

  obf_seq_ctrl #(.IGU_W(7), .PPC_W(4), .LEN_W(4), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [15:0] sub_of(input logic [6:0] i, input logic [3:0] p);
    return {1'b1, i, 4'h0, p};
  endfunction

  function automatic logic [15:0] imm_of(input logic [6:0] i, input logic [3:0] p);
    return {4'hA, 1'b0, i, p};
  endfunction

  assign bus.lut_sub = sub_of(bus.lut_index, bus.lut_ppc);
  assign bus.lut_imm = imm_of(bus.lut_index, bus.lut_ppc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        rv;
    logic [6:0]  idx;
    logic [3:0]  len;
    logic        him;
    logic        ordy;
    logic        e_rrdy;
    logic        e_ov;
    logic        e_last;
    logic        e_busy;
    logic [6:0]  e_idx;
    logic [3:0]  e_ppc;
    logic [15:0] e_sub;
    logic [15:0] e_imm;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic rv, input logic [6:0] idx,
                       input logic [3:0] len, input logic him, input logic ordy);
    bus.flush       = fl;
    bus.req_valid   = rv;
    bus.req_index   = idx;
    bus.req_len     = len;
    bus.lut_has_imm = him;
    bus.out_ready   = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0);

    // Test 2 (index 64, length 3), then back-to-back A/B, then a zero-length request.
    tbl[0]  = '{1'b0, 1'b1, 7'd64, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0,  4'd0, 16'h0, 16'h0};
    tbl[1]  = '{1'b0, 1'b0, 7'd0,  4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'd64, 4'd0, sub_of(7'd64, 4'd0), 16'h0};
    tbl[2]  = '{1'b0, 1'b0, 7'd0,  4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'd64, 4'd1, sub_of(7'd64, 4'd1), imm_of(7'd64, 4'd1)};
    tbl[3]  = '{1'b0, 1'b0, 7'd0,  4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'd64, 4'd3, sub_of(7'd64, 4'd3), 16'h0};
    tbl[4]  = '{1'b0, 1'b0, 7'd0,  4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd64, 4'd0, 16'h0, 16'h0};
    tbl[5]  = '{1'b0, 1'b1, 7'd5,  4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd64, 4'd0, 16'h0, 16'h0};
    tbl[6]  = '{1'b0, 1'b1, 7'd9,  4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'd5,  4'd0, sub_of(7'd5, 4'd0), 16'h0};
    tbl[7]  = '{1'b0, 1'b0, 7'd0,  4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'd9,  4'd0, sub_of(7'd9, 4'd0), 16'h0};
    tbl[8]  = '{1'b0, 1'b0, 7'd0,  4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'd9,  4'd1, sub_of(7'd9, 4'd1), imm_of(7'd9, 4'd1)};
    tbl[9]  = '{1'b0, 1'b1, 7'd3,  4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd9,  4'd0, 16'h0, 16'h0};
    tbl[10] = '{1'b0, 1'b0, 7'd0,  4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd9,  4'd0, 16'h0, 16'h0};

    // Check the output values while reset is held.
    #12;
    chk("rst_rrdy",  32'(bus.req_ready), 32'd1);
    chk("rst_ov",    32'(bus.out_valid), 32'd0);
    chk("rst_sub",   32'(bus.out_sub),   32'd0);
    chk("rst_imm",   32'(bus.out_imm),   32'd0);
    chk("rst_last",  32'(bus.out_last),  32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_err",   32'(bus.err),       32'd0);
    chk("rst_ppc",   32'(bus.lut_ppc),   32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].flush, tbl[i].rv, tbl[i].idx, tbl[i].len, tbl[i].him, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("v%0d_rrdy", i), 32'(bus.req_ready), 32'(tbl[i].e_rrdy));
      chk($sformatf("v%0d_ov", i),   32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_last", i), 32'(bus.out_last),  32'(tbl[i].e_last));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy),      32'(tbl[i].e_busy));
      chk($sformatf("v%0d_idx", i),  32'(bus.lut_index), 32'(tbl[i].e_idx));
      chk($sformatf("v%0d_ppc", i),  32'(bus.lut_ppc),   32'(tbl[i].e_ppc));
      chk($sformatf("v%0d_sub", i),  32'(bus.out_sub),   32'(tbl[i].e_sub));
      chk($sformatf("v%0d_imm", i),  32'(bus.out_imm),   32'(tbl[i].e_imm));
      chk($sformatf("v%0d_err", i),  32'(bus.err),       32'd0);
      tick();
    end

    // Stall: the first word is held for 4 cycles, then both words drain.
    drive(1'b0, 1'b1, 7'd20, 4'd2, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_ov", k),   32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d_sub", k),  32'(bus.out_sub),   32'(sub_of(7'd20, 4'd0)));
      chk($sformatf("stall%0d_ppc", k),  32'(bus.lut_ppc),   32'd0);
      chk($sformatf("stall%0d_rrdy", k), 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_w1_sub",  32'(bus.out_sub),  32'(sub_of(7'd20, 4'd0)));
    chk("stall_w1_last", 32'(bus.out_last), 32'd0);
    tick();
    @(negedge clk);
    chk("stall_w2_sub",  32'(bus.out_sub),  32'(sub_of(7'd20, 4'd1)));
    chk("stall_w2_last", 32'(bus.out_last), 32'd1);
    tick();
    @(negedge clk);
    chk("stall_end_ov",   32'(bus.out_valid), 32'd0);
    chk("stall_end_busy", 32'(bus.busy),      32'd0);

    // Flush during word 2 of a length-4 sequence while another request is offered.
    drive(1'b0, 1'b1, 7'd30, 4'd4, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_w1_sub", 32'(bus.out_sub), 32'(sub_of(7'd30, 4'd0)));
    tick();
    drive(1'b1, 1'b1, 7'd31, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_cyc_ov",   32'(bus.out_valid), 32'd0);
    chk("fl_cyc_rrdy", 32'(bus.req_ready), 32'd0);
    tick();
    drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_post_busy", 32'(bus.busy),      32'd0);
    chk("fl_post_ppc",  32'(bus.lut_ppc),   32'd0);
    chk("fl_post_idx",  32'(bus.lut_index), 32'd30);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("fl_quiet%0d_ov", k), 32'(bus.out_valid), 32'd0);
      tick();
    end

    // PPC overflow: length 15 where every word carries an immediate.
    drive(1'b0, 1'b1, 7'd100, 4'd15, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        bus.req_valid = 1'b1;
        bus.req_index = 7'd1;
        bus.req_len   = 4'd3;
      end
      @(negedge clk);
      chk($sformatf("ovf%0d_ov", k),   32'(bus.out_valid), 32'd1);
      chk($sformatf("ovf%0d_ppc", k),  32'(bus.lut_ppc),   32'(2 * k));
      chk($sformatf("ovf%0d_last", k), 32'(bus.out_last),  32'd0);
      chk($sformatf("ovf%0d_err", k),  32'(bus.err),       32'd0);
      if (k == 7) chk("ovf_rrdy", 32'(bus.req_ready), 32'd0);
      tick();
    end
    drive(1'b0, 1'b1, 7'd2, 4'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("ovf_err",  32'(bus.err),       32'd1);
    chk("ovf_busy", 32'(bus.busy),      32'd0);
    chk("ovf_ov",   32'(bus.out_valid), 32'd0);
    chk("ovf_ppc",  32'(bus.lut_ppc),   32'd0);
    chk("ovf_rrdy_idle", 32'(bus.req_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovf_err_clr", 32'(bus.err),       32'd0);
    chk("ovf_len0",    32'(bus.busy),      32'd0);
    chk("ovf_idx",     32'(bus.lut_index), 32'd100);
    chk("ovf_len0_ov", 32'(bus.out_valid), 32'd0);

    // Reset asserted in the middle of a sequence takes effect asynchronously.
    tick();
    drive(1'b0, 1'b1, 7'd10, 4'd3, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b1);
    tick();
    chk("mid_pre_ppc", 32'(bus.lut_ppc), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov",   32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy),      32'd0);
    chk("mid_rst_rrdy", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_ppc",  32'(bus.lut_ppc),   32'd0);
    chk("mid_rst_idx",  32'(bus.lut_index), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("mid_post%0d_ov", k), 32'(bus.out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
